// File: rtl/branch_redirect_if.sv
// EX-to-fetch redirect bundle: EX instruction in, redirect handshake and status out.
// The slave modport is the branch_redirect view; master is the surrounding pipeline.
interface branch_redirect_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 16
) ();
  logic                 i_valid;
  logic                 i_is_branch;
  logic                 i_is_jump;
  logic                 i_cmp_result;
  logic [AddrWidth-1:0] i_pc;
  logic [AddrWidth-1:0] i_offset;
  logic                 o_ex_ready;
  logic                 o_redir_valid;
  logic [AddrWidth-1:0] o_redir_pc;
  logic                 i_redir_ready;
  logic                 o_flush;
  logic [CntWidth-1:0]  o_taken_cnt;

  modport slave (
    input  i_valid, i_is_branch, i_is_jump, i_cmp_result, i_pc, i_offset, i_redir_ready,
    output o_ex_ready, o_redir_valid, o_redir_pc, o_flush, o_taken_cnt
  );

  modport master (
    output i_valid, i_is_branch, i_is_jump, i_cmp_result, i_pc, i_offset, i_redir_ready,
    input  o_ex_ready, o_redir_valid, o_redir_pc, o_flush, o_taken_cnt
  );
endinterface

// File: rtl/branch_redirect.sv
// Execute-stage branch/jump resolver: issues a fetch redirect for taken control flow,
// holds a flush window afterwards and keeps a saturating count of completed redirects.
module branch_redirect #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned FlushCycles = 2,
  parameter int unsigned CntWidth    = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  branch_redirect_if.slave bus
);

  localparam int unsigned DrainW = (FlushCycles > 1) ? $clog2(FlushCycles + 1) : 1;

  typedef enum logic [1:0] {StIdle, StRedirect, StDrain} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [DrainW-1:0]    drain_q, drain_d;
  logic [CntWidth-1:0]  taken_q, taken_d;
  logic                 taken;

  // A set jump bit wins over the branch condition.
  assign taken = bus.i_is_jump | (bus.i_is_branch & bus.i_cmp_result);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    taken_d = taken_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_valid && taken) begin
          pc_d    = bus.i_pc + bus.i_offset;
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        if (bus.i_redir_ready) begin
          if (taken_q != '1) taken_d = taken_q + CntWidth'(1);
          if (FlushCycles == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StDrain;
            drain_d = DrainW'(FlushCycles);
          end
        end
      end
      StDrain: begin
        if (drain_q <= DrainW'(1)) state_d = StIdle;
        else                       drain_d = drain_q - DrainW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      drain_q <= '0;
      taken_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      taken_q <= taken_d;
    end
  end

  // All handshake outputs decode straight from state so reset clears them immediately.
  assign bus.o_ex_ready    = (state_q == StIdle);
  assign bus.o_redir_valid = (state_q == StRedirect);
  assign bus.o_flush       = (state_q == StRedirect) || (state_q == StDrain);
  assign bus.o_redir_pc    = pc_q;
  assign bus.o_taken_cnt   = taken_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench: default-config instance plus a CntWidth=2 / FlushCycles=0 instance.
module tb_branch_redirect;
  logic i_clk;
  logic i_rst;
  int   total;
  int   bad;

  branch_redirect_if #(.AddrWidth(32), .CntWidth(16)) b0 ();
  branch_redirect_if #(.AddrWidth(32), .CntWidth(2))  b1 ();

  branch_redirect #(.AddrWidth(32), .FlushCycles(2), .CntWidth(16)) u_dut0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (b0.slave)
  );

  branch_redirect #(.AddrWidth(32), .FlushCycles(0), .CntWidth(2)) u_dut1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (b1.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic br, input logic jp, input logic cmp,
                        input logic [31:0] pc, input logic [31:0] off);
    b0.i_valid = v; b0.i_is_branch = br; b0.i_is_jump = jp; b0.i_cmp_result = cmp;
    b0.i_pc = pc; b0.i_offset = off;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    b0.i_redir_ready = 1'b1;
    b1.i_valid = 1'b0; b1.i_is_branch = 1'b0; b1.i_is_jump = 1'b0; b1.i_cmp_result = 1'b0;
    b1.i_pc = 32'h0; b1.i_offset = 32'h0; b1.i_redir_ready = 1'b1;
    #3;
    total++; if (b0.o_ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", b0.o_ex_ready); end
    total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", b0.o_redir_valid); end
    total++; if (b0.o_flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", b0.o_flush); end
    total++; if (b0.o_redir_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", b0.o_redir_pc); end
    total++; if (b0.o_taken_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", b0.o_taken_cnt); end
    tick();
    #2 i_rst = 1'b0;
    tick();
  endtask

  task automatic test_not_taken();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 1) b0.i_valid = 1'b0;
      total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL nt_valid cyc=%0d got=%b want=0", k, b0.o_redir_valid); end
      total++; if (b0.o_flush !== 1'b0) begin bad++; $display("FAIL nt_flush cyc=%0d got=%b want=0", k, b0.o_flush); end
      total++; if (b0.o_ex_ready !== 1'b1) begin bad++; $display("FAIL nt_ready cyc=%0d got=%b want=1", k, b0.o_ex_ready); end
    end
    total++; if (b0.o_taken_cnt !== 16'd0) begin bad++; $display("FAIL nt_cnt got=%0d want=0", b0.o_taken_cnt); end
  endtask

  task automatic test_taken_branch();
    logic [2:0] exp_flush;
    logic [2:0] exp_ready;
    exp_flush = 3'b110;
    exp_ready = 3'b000;
    b0.i_redir_ready = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h20);
    tick();
    b0.i_valid = 1'b0;
    total++; if (b0.o_redir_valid !== 1'b1) begin bad++; $display("FAIL tb_valid got=%b want=1", b0.o_redir_valid); end
    total++; if (b0.o_redir_pc !== 32'h120) begin bad++; $display("FAIL tb_pc got=%h want=120", b0.o_redir_pc); end
    total++; if (b0.o_flush !== 1'b1) begin bad++; $display("FAIL tb_flush0 got=%b want=1", b0.o_flush); end
    total++; if (b0.o_ex_ready !== 1'b0) begin bad++; $display("FAIL tb_ready0 got=%b want=0", b0.o_ex_ready); end
    // Two drain cycles, then back to idle.
    for (int k = 2; k >= 0; k--) begin
      tick();
      if (k == 2) begin
        total++; if (b0.o_taken_cnt !== 16'd1) begin bad++; $display("FAIL tb_cnt got=%0d want=1", b0.o_taken_cnt); end
        total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL tb_valid_drop got=%b want=0", b0.o_redir_valid); end
      end
      if (k > 0) exp_ready = 3'b000; else exp_ready = 3'b001;
      total++; if (b0.o_flush !== exp_flush[k]) begin bad++; $display("FAIL tb_flush k=%0d got=%b want=%b", k, b0.o_flush, exp_flush[k]); end
      total++; if (b0.o_ex_ready !== exp_ready[0]) begin bad++; $display("FAIL tb_ready k=%0d got=%b want=%b", k, b0.o_ex_ready, exp_ready[0]); end
    end
  endtask

  task automatic test_stall_jump();
    b0.i_redir_ready = 1'b0;
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'hFFFF_FFF0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      total++; if (b0.o_redir_valid !== 1'b1) begin bad++; $display("FAIL st_valid cyc=%0d got=%b want=1", k, b0.o_redir_valid); end
      total++; if (b0.o_redir_pc !== 32'h1F0) begin bad++; $display("FAIL st_pc cyc=%0d got=%h want=1f0", k, b0.o_redir_pc); end
      total++; if (b0.o_ex_ready !== 1'b0) begin bad++; $display("FAIL st_ready cyc=%0d got=%b want=0", k, b0.o_ex_ready); end
      total++; if (b0.o_taken_cnt !== 16'd1) begin bad++; $display("FAIL st_cnt cyc=%0d got=%0d want=1", k, b0.o_taken_cnt); end
      // Taken-looking junk while stalled must not disturb the held request.
      if (k < 5) drive0(k[0], 1'b1, 1'b0, 1'b1, 32'h5000 + k, 32'h40);
      else begin drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); b0.i_redir_ready = 1'b1; end
      tick();
    end
    total++; if (b0.o_taken_cnt !== 16'd2) begin bad++; $display("FAIL st_cnt_hs got=%0d want=2", b0.o_taken_cnt); end
    total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL st_valid_hs got=%b want=0", b0.o_redir_valid); end
    tick(); tick(); tick();
    total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL st_spurious got=%b want=0", b0.o_redir_valid); end
    total++; if (b0.o_ex_ready !== 1'b1) begin bad++; $display("FAIL st_ready_end got=%b want=1", b0.o_ex_ready); end
  endtask

  task automatic test_wrap_and_both();
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8);
    tick();
    b0.i_valid = 1'b0;
    total++; if (b0.o_redir_pc !== 32'h4) begin bad++; $display("FAIL wrap_pc got=%h want=4", b0.o_redir_pc); end
    total++; if (b0.o_redir_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", b0.o_redir_valid); end
    tick(); tick(); tick();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h10);
    tick();
    b0.i_valid = 1'b0;
    total++; if (b0.o_redir_valid !== 1'b1) begin bad++; $display("FAIL both_valid got=%b want=1", b0.o_redir_valid); end
    total++; if (b0.o_redir_pc !== 32'h310) begin bad++; $display("FAIL both_pc got=%h want=310", b0.o_redir_pc); end
    tick(); tick(); tick();
    total++; if (b0.o_taken_cnt !== 16'd4) begin bad++; $display("FAIL both_cnt got=%0d want=4", b0.o_taken_cnt); end
  endtask

  task automatic test_async_reset();
    b0.i_redir_ready = 1'b0;
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h4);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (b0.o_redir_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", b0.o_redir_valid); end
    #2 i_rst = 1'b1;
    #1;
    total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", b0.o_redir_valid); end
    total++; if (b0.o_flush !== 1'b0) begin bad++; $display("FAIL ar_flush got=%b want=0", b0.o_flush); end
    total++; if (b0.o_taken_cnt !== 16'd0) begin bad++; $display("FAIL ar_cnt got=%0d want=0", b0.o_taken_cnt); end
    #1 i_rst = 1'b0;
    b0.i_redir_ready = 1'b1;
    tick(); tick();
    total++; if (b0.o_ex_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b want=1", b0.o_ex_ready); end
    total++; if (b0.o_redir_valid !== 1'b0) begin bad++; $display("FAIL ar_spurious got=%b want=0", b0.o_redir_valid); end
    total++; if (b0.o_taken_cnt !== 16'd0) begin bad++; $display("FAIL ar_cnt_after got=%0d want=0", b0.o_taken_cnt); end
  endtask

  task automatic test_saturate_no_flush();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    b1.i_redir_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b1.i_valid = 1'b1; b1.i_is_jump = 1'b1; b1.i_pc = 32'h1000 * (k + 1); b1.i_offset = 32'h8;
      tick();
      b1.i_valid = 1'b0;
      total++; if (b1.o_redir_valid !== 1'b1 || b1.o_ex_ready !== 1'b0) begin bad++; $display("FAIL sat_redir k=%0d got=%b%b want=10", k, b1.o_redir_valid, b1.o_ex_ready); end
      tick();
      total++; if (b1.o_ex_ready !== 1'b1) begin bad++; $display("FAIL nf_ready k=%0d got=%b want=1", k, b1.o_ex_ready); end
      total++; if (b1.o_flush !== 1'b0) begin bad++; $display("FAIL nf_flush k=%0d got=%b want=0", k, b1.o_flush); end
      total++; if (b1.o_taken_cnt !== exp_cnt[k]) begin bad++; $display("FAIL sat_cnt k=%0d got=%0d want=%0d", k, b1.o_taken_cnt, exp_cnt[k]); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_not_taken();
    test_taken_branch();
    test_stall_jump();
    test_wrap_and_both();
    test_async_reset();
    test_saturate_no_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
